// File: rtl/troco_dispenser.sv
// Greedy change payout (100c, 50c, 25c), one coin per valid/ack handshake.
// Optional ack watchdog enabled by defining TROCO_TIMEOUT_EN.
module troco_dispenser #(
  parameter int VAL_W          = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [VAL_W-1:0]   valor_troco,
  input  logic [3*CNT_W-1:0] moedas_carteira,
  input  logic               moeda_ack,
  output logic               moeda_valid,
  output logic [1:0]         moeda_tipo,
  output logic [3*CNT_W-1:0] moedas_usadas,
  output logic [VAL_W-1:0]   restante,
  output logic               busy,
  output logic               pronto,
  output logic               erro
);

  typedef enum logic [2:0] {
    IDLE, CHECK, SELECT, DISPENSE, DONE
  } state_t;

  localparam logic [VAL_W-1:0] V25  = VAL_W'(25);
  localparam logic [VAL_W-1:0] V50  = VAL_W'(50);
  localparam logic [VAL_W-1:0] V100 = VAL_W'(100);
  localparam logic [1:0] T25  = 2'd0;
  localparam logic [1:0] T50  = 2'd1;
  localparam logic [1:0] T100 = 2'd2;

  state_t state;

  logic [CNT_W-1:0] n25, n50, n100;
  logic [CNT_W-1:0] u25, u50, u100;

  logic       sel_ok;
  logic [1:0] sel_tipo;
  logic [VAL_W-1:0] coin_val;

  assign moedas_usadas = {u100, u50, u25};

  // Largest coin that fits the remaining value and is in stock.
  always_comb begin
    sel_ok   = 1'b0;
    sel_tipo = T25;
    if (restante >= V100 && n100 != '0) begin
      sel_ok   = 1'b1;
      sel_tipo = T100;
    end else if (restante >= V50 && n50 != '0) begin
      sel_ok   = 1'b1;
      sel_tipo = T50;
    end else if (restante >= V25 && n25 != '0) begin
      sel_ok   = 1'b1;
      sel_tipo = T25;
    end
  end

  always_comb begin
    coin_val = V25;
    if (moeda_tipo == T100)
      coin_val = V100;
    else if (moeda_tipo == T50)
      coin_val = V50;
  end

`ifdef TROCO_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST =
    16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      moeda_valid <= 1'b0;
      moeda_tipo  <= T25;
      restante    <= '0;
      busy        <= 1'b0;
      pronto      <= 1'b0;
      erro        <= 1'b0;
      n25  <= '0;
      n50  <= '0;
      n100 <= '0;
      u25  <= '0;
      u50  <= '0;
      u100 <= '0;
`ifdef TROCO_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      pronto <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            restante <= valor_troco;
            n25  <= moedas_carteira[CNT_W-1:0];
            n50  <= moedas_carteira[2*CNT_W-1:CNT_W];
            n100 <= moedas_carteira[3*CNT_W-1:2*CNT_W];
            u25  <= '0;
            u50  <= '0;
            u100 <= '0;
            erro <= 1'b0;
            busy <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (restante == '0) begin
            pronto <= 1'b1;
            state  <= DONE;
          end else if (restante % V25 != '0) begin
            erro   <= 1'b1;
            pronto <= 1'b1;
            state  <= DONE;
          end else begin
            state <= SELECT;
          end
        end
        SELECT: begin
          if (sel_ok) begin
            moeda_valid <= 1'b1;
            moeda_tipo  <= sel_tipo;
            state       <= DISPENSE;
`ifdef TROCO_TIMEOUT_EN
            tmo <= '0;
`endif
          end else begin
            erro   <= (restante != '0);
            pronto <= 1'b1;
            state  <= DONE;
          end
        end
        DISPENSE: begin
          if (moeda_ack) begin
            restante    <= restante - coin_val;
            moeda_valid <= 1'b0;
            state       <= SELECT;
            if (moeda_tipo == T100) begin
              n100 <= n100 - 1'b1;
              u100 <= u100 + 1'b1;
            end else if (moeda_tipo == T50) begin
              n50 <= n50 - 1'b1;
              u50 <= u50 + 1'b1;
            end else begin
              n25 <= n25 - 1'b1;
              u25 <= u25 + 1'b1;
            end
          end
`ifdef TROCO_TIMEOUT_EN
          else if (tmo == TMO_LAST) begin
            moeda_valid <= 1'b0;
            erro        <= 1'b1;
            pronto      <= 1'b1;
            state       <= DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_troco_dispenser.sv
// Directed bench for troco_dispenser: payouts, errors,
// latency, stalls, ignored start, reset abort.
module tb_troco_dispenser;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  valor_troco;
  logic [23:0] moedas_carteira;
  logic        moeda_ack;
  logic        moeda_valid;
  logic [1:0]  moeda_tipo;
  logic [23:0] moedas_usadas;
  logic [7:0]  restante;
  logic        busy;
  logic        pronto;
  logic        erro;

  int vectors = 0;
  int miscompares = 0;
  logic any_valid = 1'b0;

  always #5 clock = ~clock;

  troco_dispenser #(
    .VAL_W(8),
    .CNT_W(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .valor_troco(valor_troco),
    .moedas_carteira(moedas_carteira),
    .moeda_ack(moeda_ack),
    .moeda_valid(moeda_valid),
    .moeda_tipo(moeda_tipo),
    .moedas_usadas(moedas_usadas),
    .restante(restante),
    .busy(busy),
    .pronto(pronto),
    .erro(erro)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    any_valid = any_valid | moeda_valid;
  endtask

  task automatic start_txn(input logic [7:0] v,
                           input logic [23:0] inv);
    valor_troco     = v;
    moedas_carteira = inv;
    start = 1'b1;
    tick();
    start = 1'b0;
    any_valid = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rest", 32'(restante), 32'(v));
    chk("start_erro", 32'(erro), 32'd0);
  endtask

  task automatic coin(input logic [1:0] tipo);
    for (int i = 0; i < 20 && !moeda_valid; i++)
      tick();
    chk("coin_valid", 32'(moeda_valid), 32'd1);
    chk("coin_tipo", 32'(moeda_tipo), 32'(tipo));
    moeda_ack = 1'b1;
    tick();
    moeda_ack = 1'b0;
    chk("coin_drop", 32'(moeda_valid), 32'd0);
  endtask

  task automatic fin(input logic e,
                     input logic [7:0] rest,
                     input logic [23:0] used);
    for (int i = 0; i < 30 && !pronto; i++)
      tick();
    chk("fin_pronto", 32'(pronto), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_erro", 32'(erro), 32'(e));
    chk("fin_rest", 32'(restante), 32'(rest));
    chk("fin_used", 32'(moedas_usadas), 32'(used));
    tick();
    chk("fin_pulse", 32'(pronto), 32'd0);
    chk("fin_idle", 32'(busy), 32'd0);
    chk("fin_hold", 32'(erro), 32'(e));
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    valor_troco = '0;
    moedas_carteira = '0;
    moeda_ack = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(moeda_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_rest", 32'(restante), 32'd0);
    chk("rst_used", 32'(moedas_usadas), 32'd0);
    reset_n = 1'b1;
    tick();

    // 75 with 100:2 50:1 25:1, valid latency N+3
    start_txn(8'd75, 24'h020101);
    tick();
    chk("lat_n1", 32'(moeda_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(moeda_valid), 32'd1);
    coin(2'd1);
    coin(2'd0);
    fin(1'b0, 8'd0, 24'h000101);

    // 175 with 100:1 25:3
    start_txn(8'd175, 24'h010003);
    coin(2'd2);
    coin(2'd0);
    coin(2'd0);
    coin(2'd0);
    fin(1'b0, 8'd0, 24'h010003);

    // 50 with only 100c coins
    start_txn(8'd50, 24'h030000);
    fin(1'b1, 8'd50, 24'h000000);
    chk("t3_nocoin", 32'(any_valid), 32'd0);

    // partial payout then shortfall
    start_txn(8'd100, 24'h000002);
    coin(2'd0);
    coin(2'd0);
    fin(1'b1, 8'd50, 24'h000002);
    start_txn(8'd25, 24'h000001);
    coin(2'd0);
    fin(1'b0, 8'd0, 24'h000001);

    // not a multiple of 25: pronto at N+2
    start_txn(8'd30, 24'h010101);
    chk("t4a_early", 32'(pronto), 32'd0);
    tick();
    chk("t4a_pronto", 32'(pronto), 32'd1);
    chk("t4a_erro", 32'(erro), 32'd1);
    chk("t4a_rest", 32'(restante), 32'd30);
    tick();
    chk("t4a_idle", 32'(busy), 32'd0);
    chk("t4a_nocoin", 32'(any_valid), 32'd0);

    // zero change
    start_txn(8'd0, 24'h010101);
    tick();
    chk("t4b_pronto", 32'(pronto), 32'd1);
    chk("t4b_erro", 32'(erro), 32'd0);
    tick();
    chk("t4b_idle", 32'(busy), 32'd0);

    // ack stall, ignored start, reset abort
    start_txn(8'd100, 24'h010000);
    for (int i = 0; i < 20 && !moeda_valid; i++)
      tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        valor_troco = 8'd25;
        moedas_carteira = 24'h000005;
        start = 1'b1;
      end
      if (i == 4)
        start = 1'b0;
      tick();
      chk("t5_valid", 32'(moeda_valid), 32'd1);
      chk("t5_tipo", 32'(moeda_tipo), 32'd2);
    end
    chk("t5_rest", 32'(restante), 32'd100);
    chk("t5_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("t5r_valid", 32'(moeda_valid), 32'd0);
    chk("t5r_tipo", 32'(moeda_tipo), 32'd0);
    chk("t5r_busy", 32'(busy), 32'd0);
    chk("t5r_pronto", 32'(pronto), 32'd0);
    chk("t5r_erro", 32'(erro), 32'd0);
    chk("t5r_rest", 32'(restante), 32'd0);
    chk("t5r_used", 32'(moedas_usadas), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("t5r_nopr", 32'(pronto), 32'd0);
    start_txn(8'd0, 24'h000000);
    tick();
    chk("t5_after", 32'(pronto), 32'd1);
    tick();

`ifdef TROCO_TIMEOUT_EN
    begin
      int n;
      n = 0;
      start_txn(8'd100, 24'h010000);
      for (int i = 0; i < 20 && !moeda_valid; i++)
        tick();
      for (int i = 0; i < 20 && moeda_valid; i++) begin
        tick();
        n++;
      end
      chk("t6_cycles", 32'(n), 32'd8);
      chk("t6_pronto", 32'(pronto), 32'd1);
      chk("t6_erro", 32'(erro), 32'd1);
      chk("t6_rest", 32'(restante), 32'd100);
      chk("t6_used", 32'(moedas_usadas), 32'd0);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
